// File: rtl/systolic_feeder.sv
// Operand skew feeder: buffers whole vectors per lane and issues lane k
// strictly behind lane k-1, forming the diagonal wavefront for the MAC array.
module systolic_feeder_lane #(
   parameter int width_p = 32,
   parameter int depth_p = 8
) (
   input  logic                      clk_i,
   input  logic                      reset_n_i,
   input  logic                      push_i,
   input  logic                      pop_i,
   input  logic [width_p-1:0]        data_i,
   output logic [$clog2(depth_p):0]  occ_o,
   output logic [width_p-1:0]        data_o
);
   localparam int PTR_W = $clog2(depth_p);
   localparam int OCC_W = PTR_W + 1;

   logic [PTR_W-1:0]                wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]                rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]                occ_q, occ_d;
   logic [depth_p-1:0][width_p-1:0] mem_q, mem_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      mem_d    = mem_q;
      if (push_i) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
         2'b10:   occ_d = occ_q + OCC_W'(1);
         2'b01:   occ_d = occ_q - OCC_W'(1);
         default: occ_d = occ_q;
      endcase
   end

   // Storage is cleared too so the read port never exposes unwritten slots.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         mem_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         mem_q    <= mem_d;
      end
   end

   assign occ_o  = occ_q;
   assign data_o = mem_q[rd_ptr_q];
endmodule

module systolic_feeder #(
   parameter int width_p = 32,
   parameter int lanes_p = 4,
   parameter int depth_p = 8
) (
   input  logic                       clk_i,
   input  logic                       reset_n_i,
   input  logic                       en_i,
   input  logic                       vec_valid_i,
   output logic                       vec_ready_o,
   input  logic [lanes_p*width_p-1:0] vec_i,
   output logic [lanes_p-1:0]         lane_valid_o,
   input  logic [lanes_p-1:0]         lane_ready_i,
   output logic [lanes_p*width_p-1:0] lane_data_o,
   output logic                       idle_o
);
   localparam int OCC_W = $clog2(depth_p) + 1;

   logic [lanes_p-1:0][OCC_W-1:0] occ;
   logic [lanes_p-1:0]            pop;
   logic                          push;

   // The last lane is always the fullest, so it alone gates acceptance and idle.
   assign vec_ready_o = en_i & (occ[lanes_p-1] != OCC_W'(depth_p));
   assign idle_o      = (occ[lanes_p-1] == '0);
   assign push        = vec_valid_i & vec_ready_o;
   assign pop         = lane_valid_o & lane_ready_i;

   always_comb begin
      lane_valid_o    = '0;
      lane_valid_o[0] = en_i & (occ[0] != '0);
      for (int k = 1; k < lanes_p; k++)
         lane_valid_o[k] = en_i & (occ[k] > occ[k-1]);
   end

   for (genvar k = 0; k < lanes_p; k++) begin : g_lane
      systolic_feeder_lane #(
         .width_p (width_p),
         .depth_p (depth_p)
      ) u_lane (
         .clk_i     (clk_i),
         .reset_n_i (reset_n_i),
         .push_i    (push),
         .pop_i     (pop[k]),
         .data_i    (vec_i[k*width_p +: width_p]),
         .occ_o     (occ[k]),
         .data_o    (lane_data_o[k*width_p +: width_p])
      );
   end
endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized scoreboard bench for systolic_feeder against a per-lane queue model.
module tb_systolic_feeder;
   localparam int W = 32;
   localparam int L = 4;
   localparam int D = 8;

   logic           clk_i = 1'b0;
   logic           reset_n_i = 1'b0;
   logic           en_i = 1'b1;
   logic           vec_valid_i = 1'b0;
   logic           vec_ready_o;
   logic [L*W-1:0] vec_i = '0;
   logic [L-1:0]   lane_valid_o;
   logic [L-1:0]   lane_ready_i = '0;
   logic [L*W-1:0] lane_data_o;
   logic           idle_o;

   int  total = 0;
   int  bad = 0;
   bit  mon_en = 0;
   bit  rnd_done = 0;

   // Model: lane k queue holds elements pushed but not yet issued on lane k.
   logic [W-1:0] q [L][$];

   systolic_feeder #(.width_p(W), .lanes_p(L), .depth_p(D)) dut (
      .clk_i        (clk_i),
      .reset_n_i    (reset_n_i),
      .en_i         (en_i),
      .vec_valid_i  (vec_valid_i),
      .vec_ready_o  (vec_ready_o),
      .vec_i        (vec_i),
      .lane_valid_o (lane_valid_o),
      .lane_ready_i (lane_ready_i),
      .lane_data_o  (lane_data_o),
      .idle_o       (idle_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [L*W-1:0] mk(input int a, input int b, input int c, input int d);
      return {W'(d), W'(c), W'(b), W'(a)};
   endfunction

   function automatic logic [W-1:0] lane_of(input logic [L*W-1:0] v, input int k);
      return v[k*W +: W];
   endfunction

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push_vec(input logic [L*W-1:0] v);
      bit acc;
      acc = 0;
      vec_i = v;
      vec_valid_i = 1'b1;
      for (int t = 0; t < 200 && !acc; t++) begin
         acc = vec_ready_o && en_i;
         step();
      end
      vec_valid_i = 1'b0;
      chk("push_accept", 64'(acc), 64'd1);
   endtask

   task automatic drain();
      lane_ready_i = '1;
      for (int t = 0; t < 200 && !idle_o; t++) step();
      chk("drain_idle", 64'(idle_o), 64'd1);
   endtask

   // Monitor: compares handshake outputs to the model, then applies the
   // transfers that the upcoming rising edge will perform.
   always @(negedge clk_i) begin
      if (mon_en) begin
         logic         exp_rdy;
         logic [L-1:0] exp_v;
         exp_rdy = en_i && (q[L-1].size() != D);
         exp_v = '0;
         exp_v[0] = en_i && (q[0].size() != 0);
         for (int k = 1; k < L; k++) exp_v[k] = en_i && (q[k].size() > q[k-1].size());
         chk("vec_ready", 64'(vec_ready_o), 64'(exp_rdy));
         chk("lane_valid", 64'(lane_valid_o), 64'(exp_v));
         chk("idle", 64'(idle_o), 64'(q[L-1].size() == 0));
         if (!reset_n_i) begin
            for (int k = 0; k < L; k++) q[k].delete();
         end else begin
            for (int k = 0; k < L; k++) begin
               if (exp_v[k] && lane_ready_i[k]) begin
                  if (q[k].size() == 0) chk("lane_underflow", 64'(k), 64'(L));
                  else chk($sformatf("lane%0d_data", k), 64'(lane_of(lane_data_o, k)), 64'(q[k].pop_front()));
               end
            end
            if (exp_rdy && vec_valid_i)
               for (int k = 0; k < L; k++) q[k].push_back(lane_of(vec_i, k));
         end
      end
   end

   initial begin
      step();
      step();
      reset_n_i = 1'b1;
      mon_en = 1;
      chk("rst_vec_ready", 64'(vec_ready_o), 64'd1);
      chk("rst_lane_valid", 64'(lane_valid_o), 64'd0);
      chk("rst_idle", 64'(idle_o), 64'd1);

      // Directed diagonal wavefront.
      lane_ready_i = '1;
      push_vec(mk(1, 2, 3, 4));
      chk("t1_lane0_first_valid", 64'(lane_valid_o), 64'h1);
      chk("t1_lane0_first_data", 64'(lane_of(lane_data_o, 0)), 64'd1);
      push_vec(mk(5, 6, 7, 8));
      push_vec(mk(9, 10, 11, 12));
      step();
      chk("t1_lane3_valid_cycle4", 64'(lane_valid_o), 64'hE);
      chk("t1_lane3_first_data", 64'(lane_of(lane_data_o, 3)), 64'd4);
      drain();

      // Fill to depth, then free only lane 0.
      lane_ready_i = '0;
      for (int i = 0; i < D; i++) push_vec(mk(100 + i, 200 + i, 300 + i, 400 + i));
      chk("t2_full_ready", 64'(vec_ready_o), 64'd0);
      lane_ready_i = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t2_lane0_only_ready", 64'(vec_ready_o), 64'd0);
      end
      drain();

      // Lane 1 stalled for 3 cycles mid-stream.
      lane_ready_i = '1;
      for (int i = 0; i < 6; i++) begin
         if (i == 2) lane_ready_i = 4'b1101;
         if (i == 5) lane_ready_i = 4'b1111;
         push_vec(mk(20 + i, 30 + i, 40 + i, 50 + i));
      end
      drain();

      // Random stream with random per-lane ready.
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               while ($urandom_range(0, 3) == 0) step();
               push_vec({$urandom, $urandom, $urandom, $urandom});
            end
            rnd_done = 1;
         end
         begin
            while (!rnd_done) begin
               lane_ready_i = 4'($urandom);
               step();
            end
         end
      join
      drain();

      // Enable held low with everything asking to transfer.
      lane_ready_i = '0;
      push_vec(mk(61, 62, 63, 64));
      push_vec(mk(65, 66, 67, 68));
      vec_i = mk(69, 70, 71, 72);
      vec_valid_i = 1'b1;
      lane_ready_i = '1;
      en_i = 1'b0;
      #1;
      chk("t5_en0_ready", 64'(vec_ready_o), 64'd0);
      chk("t5_en0_valid", 64'(lane_valid_o), 64'd0);
      step();
      step();
      chk("t5_en0_idle_held", 64'(idle_o), 64'd0);
      en_i = 1'b1;
      push_vec(mk(69, 70, 71, 72));
      drain();

      // Reset with vectors buffered.
      lane_ready_i = '0;
      for (int i = 0; i < 3; i++) push_vec(mk(80 + i, 81 + i, 82 + i, 83 + i));
      reset_n_i = 1'b0;
      step();
      reset_n_i = 1'b1;
      chk("t6_idle_after_rst", 64'(idle_o), 64'd1);
      chk("t6_valid_after_rst", 64'(lane_valid_o), 64'd0);
      lane_ready_i = '1;
      push_vec(mk(7, 7, 7, 7));
      chk("t6_lane0_valid", 64'(lane_valid_o), 64'h1);
      chk("t6_lane0_data", 64'(lane_of(lane_data_o, 0)), 64'd7);
      drain();

      step();
      step();
      mon_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
